// File: rtl/biss_c_slave_emu_if.sv
// MA/SLO line pair of a BiSS-C point-to-point link.
// The master drives MA (clock, idle high) and the slave drives SLO (data, idle high).
interface biss_c_slave_emu_if;
    logic ma;
    logic slo;

    modport master (output ma, input slo);
    modport slave  (input ma, output slo);
endinterface

// File: rtl/biss_c_slave_emu.sv
// BiSS-C encoder-side responder.
// Clocked by MA from the master. Each frame sends ACK, Start, CDS, the position
// (MSB first), nE and nW, then the inverted CRC6. After that SLO is held low
// (BiSS timeout) until MA has been high long enough, and then SLO returns high.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | slo high; waiting for an MA fall to start a frame
// S_ACK     | slo low for ACK_BITS MA rises
// S_START   | next rise drives the Start bit (1)
// S_CDS     | next rise drives the CDS bit (0)
// S_DATA    | rises shift out position[MSB..0], nE, nW; each bit feeds the CRC
// S_CRC     | rises shift out ~crc[5..0]; frame_done pulses on the last bit
// S_TIMEOUT | slo low; returns to idle after TIMEOUT_CYC cycles of MA high
module biss_c_slave_emu #(
    parameter int POS_WIDTH   = 32,
    parameter int ACK_BITS    = 1,
    parameter int TIMEOUT_CYC = 100,
    parameter int ABORT_CYC   = 2000
) (
    input  logic                 clk,
    input  logic                 reset,
    biss_c_slave_emu_if.slave    bus,
    input  logic [POS_WIDTH-1:0] position_in,
    input  logic                 error_in,
    input  logic                 warn_in,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 frame_abort
);

    // Shift register holds position followed by nE and nW.
    localparam int DATA_BITS = POS_WIDTH + 2;

    // The edge counter has to reach the longest per-state bit count.
    localparam int BIT_MAX   = (DATA_BITS > ACK_BITS) ? DATA_BITS : ACK_BITS;
    localparam int BIT_CNT_W = ($clog2(BIT_MAX + 1) > 6) ? $clog2(BIT_MAX + 1) : 6;

    // One counter serves both the mid-frame abort and the post-frame timeout.
    localparam int TMO_MAX   = (ABORT_CYC > TIMEOUT_CYC) ? ABORT_CYC : TIMEOUT_CYC;
    localparam int TMO_CNT_W = $clog2(TMO_MAX + 1);

    localparam logic [BIT_CNT_W-1:0] ACK_LAST  = BIT_CNT_W'(ACK_BITS - 1);
    localparam logic [BIT_CNT_W-1:0] DATA_LAST = BIT_CNT_W'(DATA_BITS - 1);
    localparam logic [BIT_CNT_W-1:0] CRC_LAST  = BIT_CNT_W'(5);
    localparam logic [TMO_CNT_W-1:0] ABORT_LIM = TMO_CNT_W'(ABORT_CYC);
    localparam logic [TMO_CNT_W-1:0] TMO_LIM   = TMO_CNT_W'(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACK,
        S_START,
        S_CDS,
        S_DATA,
        S_CRC,
        S_TIMEOUT
    } state_t;

    state_t                 state;
    logic                   ma_s1;
    logic                   ma_s2;
    logic                   ma_s3;
    logic                   ma_rise;
    logic                   ma_fall;
    logic                   slo_q;
    logic [DATA_BITS-1:0]   data_sr;
    logic [5:0]             crc;
    logic [5:0]             crc_next;
    logic                   crc_fb;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [BIT_CNT_W-1:0]   bit_inc;
    logic [TMO_CNT_W-1:0]   tmo_cnt;
    logic [TMO_CNT_W-1:0]   tmo_inc;
    logic                   abort_hit;
    logic                   timeout_hit;

    assign bus.slo = slo_q;

    // Two-stage synchroniser for the asynchronous MA line plus one stage for edge detect.
    // Reset to 1 so an idle-high MA produces no spurious edge after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ma_s1 <= 1'b1;
            ma_s2 <= 1'b1;
            ma_s3 <= 1'b1;
        end else begin
            ma_s1 <= bus.ma;
            ma_s2 <= ma_s1;
            ma_s3 <= ma_s2;
        end
    end

    assign ma_rise = ma_s2 & ~ma_s3;
    assign ma_fall = ~ma_s2 & ma_s3;

    // Saturating increments, CRC6 (x^6+x+1) step and counter compares for the FSM.
    always_comb begin
        bit_inc     = (bit_cnt == '1) ? bit_cnt : bit_cnt + 1'b1;
        tmo_inc     = (tmo_cnt == '1) ? tmo_cnt : tmo_cnt + 1'b1;
        abort_hit   = ma_s2 && (tmo_inc == ABORT_LIM);
        timeout_hit = ma_s2 && (tmo_inc == TMO_LIM);
        crc_fb      = crc[5] ^ data_sr[DATA_BITS-1];
        crc_next    = {crc[4:0], 1'b0} ^ (crc_fb ? 6'h03 : 6'h00);
    end

    // Frame sequencer: all outputs are registered and update on the cycle after an MA edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            slo_q       <= 1'b1;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            data_sr     <= '0;
            crc         <= '0;
            bit_cnt     <= '0;
            tmo_cnt     <= '0;
        end else begin
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            case (state)
                S_IDLE: begin
                    slo_q   <= 1'b1;
                    tmo_cnt <= '0;
                    if (ma_fall) begin
                        data_sr <= {position_in, ~error_in, ~warn_in};
                        crc     <= '0;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= S_ACK;
                    end
                end

                S_TIMEOUT: begin
                    // A low MA here only restarts the count; frames start from idle only.
                    if (!ma_s2) begin
                        tmo_cnt <= '0;
                    end else if (timeout_hit) begin
                        slo_q   <= 1'b1;
                        busy    <= 1'b0;
                        tmo_cnt <= '0;
                        state   <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_inc;
                        if (ma_rise) begin
                            slo_q <= 1'b0;
                        end
                    end
                end

                default: begin
                    // In-frame states: a master that parks MA high for too long loses the frame.
                    if (abort_hit) begin
                        slo_q       <= 1'b0;
                        tmo_cnt     <= '0;
                        bit_cnt     <= '0;
                        frame_abort <= 1'b1;
                        state       <= S_TIMEOUT;
                    end else begin
                        tmo_cnt <= ma_s2 ? tmo_inc : '0;
                        if (ma_rise) begin
                            case (state)
                                S_ACK: begin
                                    slo_q <= 1'b0;
                                    if (bit_cnt == ACK_LAST) begin
                                        bit_cnt <= '0;
                                        state   <= S_START;
                                    end else begin
                                        bit_cnt <= bit_inc;
                                    end
                                end
                                S_START: begin
                                    slo_q <= 1'b1;
                                    state <= S_CDS;
                                end
                                S_CDS: begin
                                    slo_q <= 1'b0;
                                    state <= S_DATA;
                                end
                                S_DATA: begin
                                    slo_q   <= data_sr[DATA_BITS-1];
                                    data_sr <= {data_sr[DATA_BITS-2:0], 1'b0};
                                    crc     <= crc_next;
                                    if (bit_cnt == DATA_LAST) begin
                                        bit_cnt <= '0;
                                        state   <= S_CRC;
                                    end else begin
                                        bit_cnt <= bit_inc;
                                    end
                                end
                                S_CRC: begin
                                    slo_q <= ~crc[5];
                                    crc   <= {crc[4:0], 1'b0};
                                    if (bit_cnt == CRC_LAST) begin
                                        bit_cnt    <= '0;
                                        frame_done <= 1'b1;
                                        state      <= S_TIMEOUT;
                                    end else begin
                                        bit_cnt <= bit_inc;
                                    end
                                end
                                default: begin
                                    state <= S_IDLE;
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule
